// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imemReq  : read request, held with imemAddr until imemAck
//   imemAddr : word-aligned read address
//   imemAck  : response strobe, imemData valid in the same cycle
//   imemData : returned instruction word
interface pc_fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;

  // Fetch unit side.
  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemData
  );

  // Memory side.
  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemData
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction fetch unit.
// Fetches one instruction at currentPC over the imem bus, holds it for decode until it is
// consumed (stall = 0), then loads the next PC from the branch/jump select stage.
//   clk, rst_n   : clock and asynchronous active-low reset
//   nextPC       : next PC, sampled only when an instruction is consumed
//   stall        : 1 = held instruction not consumed this cycle
//   imem         : instruction-memory bus (master side)
//   instrValid   : instruction/currentPC valid for decode
//   instruction  : registered fetched instruction
//   currentPC    : PC of the held instruction; also the fetch address
//   pcPlus4      : currentPC + 4 (wraps modulo 2^32)
//   alignErr     : sticky, a misaligned nextPC was consumed
//   instrCount   : number of consumed instructions (wraps)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             nextPC,
  input  logic                    stall,
  pc_fetch_unit_if.master         imem,
  output logic                    instrValid,
  output logic [31:0]             instruction,
  output logic [31:0]             currentPC,
  output logic [31:0]             pcPlus4,
  output logic                    alignErr,
  output logic [31:0]             instrCount
);

  typedef enum logic [1:0] {StIdle, StReq, StValid} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        align_q, align_d;
  logic [31:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    align_d = align_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (imem.imemAck) begin
          instr_d = imem.imemData;
          valid_d = 1'b1;
          state_d = StValid;
        end
      end
      StValid: begin
        // Acks arriving here are stray and must not touch the held instruction.
        if (!stall) begin
          pc_d    = {nextPC[31:2], 2'b00};
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          if (nextPC[1:0] != 2'b00) begin
            align_d = 1'b1;
          end
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      align_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      align_q <= align_d;
      count_q <= count_d;
    end
  end

  // Request is a pure decode of the state register, so it is glitch-free and held until ack.
  assign imem.imemReq  = (state_q == StReq);
  assign imem.imemAddr = pc_q;

  assign instrValid  = valid_q;
  assign instruction = instr_q;
  assign currentPC   = pc_q;
  assign pcPlus4     = pc_q + 32'd4;
  assign alignErr    = align_q;
  assign instrCount  = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        stall = 1'b1;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] current_pc;
  logic [31:0] pc_plus4;
  logic        align_err;
  logic [31:0] instr_count;

  pc_fetch_unit_if imem_if ();

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nextPC      (next_pc),
    .stall       (stall),
    .imem        (imem_if),
    .instrValid  (instr_valid),
    .instruction (instruction),
    .currentPC   (current_pc),
    .pcPlus4     (pc_plus4),
    .alignErr    (align_err),
    .instrCount  (instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected fetch addresses and captured instructions.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_align;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'h0, imem_if.imemReq}, 32'h0);
    chk({tag, "_pc"},    current_pc, RESET_PC);
    chk({tag, "_addr"},  imem_if.imemAddr, RESET_PC);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_align"}, {31'h0, align_err}, 32'h0);
    chk({tag, "_count"}, instr_count, 32'h0);
  endtask

  // Called with the DUT in REQ: hold off ack for wait_cycles, then return data.
  task automatic fetch(input logic [31:0] data, input int wait_cycles);
    logic [31:0] ea;
    checks++;
    assert (exp_addr_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_addr_empty observed=0 expected=1");
    end
    ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'h0;
    chk("req_high", {31'h0, imem_if.imemReq}, 32'h1);
    chk("req_addr", imem_if.imemAddr, ea);
    chk("pc_plus4", pc_plus4, ea + 32'd4);
    for (int i = 0; i < wait_cycles; i++) begin
      stall = $urandom_range(0, 1) == 1;
      cyc();
      chk("req_hold", {31'h0, imem_if.imemReq}, 32'h1);
      chk("addr_hold", imem_if.imemAddr, ea);
      chk("valid_wait", {31'h0, instr_valid}, 32'h0);
    end
    imem_if.imemAck = 1'b1;
    imem_if.imemData = data;
    exp_instr_q.push_back(data);
    m_instr = data;
    cyc();
    imem_if.imemAck = 1'b0;
    imem_if.imemData = $urandom;
    chk("valid_high", {31'h0, instr_valid}, 32'h1);
    chk("req_low", {31'h0, imem_if.imemReq}, 32'h0);
    checks++;
    assert (exp_instr_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_instr_empty observed=0 expected=1");
    end
    if (exp_instr_q.size() != 0) chk("instr", instruction, exp_instr_q.pop_front());
  endtask

  // Called with the DUT in VALID: stall n_stall cycles (with stray acks), then consume npc.
  task automatic consume(input logic [31:0] npc, input int n_stall);
    for (int i = 0; i < n_stall; i++) begin
      stall = 1'b1;
      next_pc = $urandom;
      imem_if.imemAck = 1'b1;
      imem_if.imemData = $urandom;
      cyc();
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_instr", instruction, m_instr);
      chk("stall_pc", current_pc, m_pc);
      chk("stall_count", instr_count, m_cnt);
    end
    imem_if.imemAck = 1'b0;
    stall = 1'b0;
    next_pc = npc;
    cyc();
    stall = 1'b1;
    m_pc = {npc[31:2], 2'b00};
    m_cnt = m_cnt + 32'd1;
    if (npc[1:0] != 2'b00) m_align = 1'b1;
    exp_addr_q.push_back(m_pc);
    chk("cons_valid", {31'h0, instr_valid}, 32'h0);
    chk("cons_pc", current_pc, m_pc);
    chk("cons_count", instr_count, m_cnt);
    chk("cons_align", {31'h0, align_err}, {31'h0, m_align});
    chk("cons_instr", instruction, m_instr);
  endtask

  initial begin
    imem_if.imemAck = 1'b0;
    imem_if.imemData = 32'h0;
    m_pc = RESET_PC;
    m_cnt = 32'h0;
    m_align = 1'b0;
    m_instr = 32'h0;

    #2;
    chk_reset("rst");
    // Ack present while still in IDLE must be ignored.
    #10;
    imem_if.imemAck = 1'b1;
    imem_if.imemData = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'h0, imem_if.imemReq}, 32'h0);
    cyc();
    chk("first_req", {31'h0, imem_if.imemReq}, 32'h1);
    chk("idle_ack_ignored", instruction, 32'h0);
    imem_if.imemAck = 1'b0;
    exp_addr_q.push_back(RESET_PC);

    // Zero-wait streaming, sequential PCs.
    for (int k = 0; k < 3; k++) begin
      fetch(32'h2008_000A, 0);
      consume(m_pc + 32'd4, 0);
    end
    chk("count3", instr_count, 32'd3);

    // Long memory wait, then a stalled decode with nextPC toggling.
    fetch(32'h1234_5678, 5);
    consume(m_pc + 32'd4, 4);

    // Jump, then misaligned jump (sticky error).
    fetch(32'h0000_0013, 0);
    consume(32'h0040_0020, 0);
    fetch(32'hABCD_0001, 1);
    consume(32'h0000_0006, 0);
    fetch(32'h5555_AAAA, 0);
    consume(m_pc + 32'd4, 2);
    chk("align_sticky", {31'h0, align_err}, 32'h1);

    // Top-of-address-space wrap.
    fetch(32'h0BAD_F00D, 0);
    consume(32'hFFFF_FFFC, 0);
    fetch(32'h7777_0000, 0);
    chk("wrap_plus4", pc_plus4, 32'h0);
    consume(m_pc + 32'd4, 0);
    chk("wrap_addr", imem_if.imemAddr, 32'h0);
    chk("wrap_req", {31'h0, imem_if.imemReq}, 32'h1);

    // Asynchronous reset mid-REQ with an ack pending.
    #2;
    imem_if.imemAck = 1'b1;
    imem_if.imemData = 32'hCAFE_BABE;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    cyc();
    chk_reset("rst_held");
    #3;
    rst_n = 1'b1;
    cyc();
    chk("rst_idle_ack", instruction, 32'h0);
    chk("rst_restart_req", {31'h0, imem_if.imemReq}, 32'h1);
    chk("rst_align_clr", {31'h0, align_err}, 32'h0);
    imem_if.imemAck = 1'b0;
    exp_addr_q.delete();
    exp_instr_q.delete();
    m_pc = RESET_PC;
    m_cnt = 32'h0;
    m_align = 1'b0;
    exp_addr_q.push_back(RESET_PC);
    fetch(32'h0000_1111, 0);
    consume(m_pc + 32'd4, 0);
    chk("post_rst_count", instr_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
